chroni_text_engine: RTL

Parametrised text-mode line renderer for chroni.
- Fetches one row of character codes from VRAM into an internal text buffer.
- On every scanline, fetches one font byte per column and pushes it to the chroni line buffer as an 8-pixel bitmap write.
- Over the previous generation it adds programmable text/font base addresses, parametrised columns and font height, row advance, an overrun flag and optional per-cell attributes.

---
 rtl/chroni_text_engine_if.sv | 28 ++
 rtl/chroni_text_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/chroni_text_engine_if.sv
// VRAM read port and line-buffer write port of the chroni text engine.
// Handshake: the engine raises mem_rd_req with a stable mem_addr and holds it until it samples
// mem_rd_ack (mem_data valid in that cycle); lb_wr_en is a one-cycle write issued only after lb_wr_busy was seen low.
interface chroni_text_engine_if #(
    parameter int ADDR_W    = 16,
    parameter int LB_ADDR_W = 11
);
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_rd_req;
    logic                 mem_rd_ack;
    logic [7:0]           mem_data;
    logic                 lb_wr_en;
    logic [LB_ADDR_W-1:0] lb_wr_addr;
    logic [7:0]           lb_wr_data;
    logic [7:0]           lb_bitmap_on;
    logic [7:0]           lb_bitmap_off;
    logic                 lb_wr_busy;

    modport master (
        output mem_addr, mem_rd_req, lb_wr_en, lb_wr_addr, lb_wr_data, lb_bitmap_on, lb_bitmap_off,
        input  mem_rd_ack, mem_data, lb_wr_busy
    );

    modport slave (
        input  mem_addr, mem_rd_req, lb_wr_en, lb_wr_addr, lb_wr_data, lb_bitmap_on, lb_bitmap_off,
        output mem_rd_ack, mem_data, lb_wr_busy
    );
endinterface

// File: rtl/chroni_text_engine.sv
// chroni text-mode line renderer: loads a row of character codes, then pushes one font byte per column per scanline.
// Per-cell colour attributes are added when CHRONI_TEXT_ATTR_EN is defined.
module chroni_text_engine #(
    parameter int COLS      = 80,
    parameter int COL_W     = 7,
    parameter int SCAN_W    = 3,
    parameter int ADDR_W    = 16,
    parameter int LB_ADDR_W = 11,
    parameter int LB_HALF   = 640
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic                 line_start,
    input  logic                 line_buffer_sel,
    input  logic [ADDR_W-1:0]    text_base,
    input  logic [ADDR_W-1:0]    font_base,
`ifdef CHRONI_TEXT_ATTR_EN
    input  logic [ADDR_W-1:0]    attr_base,
`endif
    chroni_text_engine_if.master bus,
    output logic                 busy,
    output logic                 line_done,
    output logic                 overrun,
    output logic [2:0]           dbg_state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TEXT_REQ  = 3'd1,
        TEXT_WAIT = 3'd2,
        ATTR_REQ  = 3'd3,
        ATTR_WAIT = 3'd4,
        FONT_REQ  = 3'd5,
        FONT_WAIT = 3'd6,
        FONT_PUSH = 3'd7
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [SCAN_W-1:0] scan;
    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] font_q;
    logic              first_line;
    logic [7:0]        font_byte;

    // Sized to the column index range so every col value maps to a real entry.
    logic [7:0]        text_buf [2**COL_W];
`ifdef CHRONI_TEXT_ATTR_EN
    logic [7:0]        attr_buf [2**COL_W];
    logic [ADDR_W-1:0] text_base_q;
    logic              attr_wr;
`endif

    logic [SCAN_W-1:0] scan_eff;
    logic              last_col;
    logic              text_wr;
    logic [ADDR_W-1:0] font_addr;

    always_comb begin
        scan_eff  = first_line ? scan : scan + 1'b1;
        last_col  = (col == COL_W'(COLS - 1));
        font_addr = font_q + (ADDR_W'(text_buf[col]) << SCAN_W) + ADDR_W'(scan);
        text_wr   = (state == TEXT_WAIT) && bus.mem_rd_ack && !frame_start && !line_start;
    end

`ifdef CHRONI_TEXT_ATTR_EN
    assign attr_wr = (state == ATTR_WAIT) && bus.mem_rd_ack && !frame_start && !line_start;
`endif

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge sys_clk) begin
        if (text_wr) text_buf[col] <= bus.mem_data;
`ifdef CHRONI_TEXT_ATTR_EN
        if (attr_wr) attr_buf[col] <= bus.mem_data;
`endif
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            col               <= '0;
            scan              <= '0;
            row_addr          <= '0;
            font_q            <= '0;
            first_line        <= 1'b1;
            font_byte         <= '0;
            bus.mem_addr      <= '0;
            bus.mem_rd_req    <= 1'b0;
            bus.lb_wr_en      <= 1'b0;
            bus.lb_wr_addr    <= '0;
            bus.lb_wr_data    <= '0;
            bus.lb_bitmap_on  <= '0;
            bus.lb_bitmap_off <= '0;
            line_done         <= 1'b0;
            overrun           <= 1'b0;
`ifdef CHRONI_TEXT_ATTR_EN
            text_base_q       <= '0;
`endif
        end else begin
            bus.lb_wr_en <= 1'b0;
            line_done    <= 1'b0;
            overrun      <= 1'b0;
            if (frame_start) begin
                row_addr       <= text_base;
                scan           <= '0;
                first_line     <= 1'b1;
                bus.mem_rd_req <= 1'b0;
                state          <= IDLE;
`ifdef CHRONI_TEXT_ATTR_EN
                text_base_q    <= text_base;
`endif
            end else if (line_start) begin
                // A line_start while busy abandons the line in flight, including any open read.
                overrun        <= (state != IDLE);
                scan           <= scan_eff;
                if (!first_line && scan_eff == '0) row_addr <= row_addr + ADDR_W'(COLS);
                first_line     <= 1'b0;
                col            <= '0;
                font_q         <= font_base;
                bus.lb_wr_addr <= line_buffer_sel ? LB_ADDR_W'(LB_HALF) : '0;
                bus.mem_rd_req <= 1'b0;
                state          <= (scan_eff == '0) ? TEXT_REQ : FONT_REQ;
            end else begin
                case (state)
                    TEXT_REQ: begin
                        bus.mem_addr   <= row_addr + ADDR_W'(col);
                        bus.mem_rd_req <= 1'b1;
                        state          <= TEXT_WAIT;
                    end
                    TEXT_WAIT: begin
                        if (bus.mem_rd_ack) begin
                            bus.mem_rd_req <= 1'b0;
`ifdef CHRONI_TEXT_ATTR_EN
                            state <= ATTR_REQ;
`else
                            if (last_col) begin
                                col   <= '0;
                                state <= FONT_REQ;
                            end else begin
                                col   <= col + 1'b1;
                                state <= TEXT_REQ;
                            end
`endif
                        end
                    end
`ifdef CHRONI_TEXT_ATTR_EN
                    ATTR_REQ: begin
                        bus.mem_addr   <= attr_base + (row_addr - text_base_q) + ADDR_W'(col);
                        bus.mem_rd_req <= 1'b1;
                        state          <= ATTR_WAIT;
                    end
                    ATTR_WAIT: begin
                        if (bus.mem_rd_ack) begin
                            bus.mem_rd_req <= 1'b0;
                            if (last_col) begin
                                col   <= '0;
                                state <= FONT_REQ;
                            end else begin
                                col   <= col + 1'b1;
                                state <= TEXT_REQ;
                            end
                        end
                    end
`endif
                    FONT_REQ: begin
                        // The write of the previous column is on the bus this cycle; step the address after it.
                        if (bus.lb_wr_en) bus.lb_wr_addr <= bus.lb_wr_addr + LB_ADDR_W'(8);
                        bus.mem_addr   <= font_addr;
                        bus.mem_rd_req <= 1'b1;
                        state          <= FONT_WAIT;
                    end
                    FONT_WAIT: begin
                        if (bus.mem_rd_ack) begin
                            font_byte      <= bus.mem_data;
                            bus.mem_rd_req <= 1'b0;
                            state          <= FONT_PUSH;
                        end
                    end
                    FONT_PUSH: begin
                        if (!bus.lb_wr_busy) begin
                            bus.lb_wr_en   <= 1'b1;
                            bus.lb_wr_data <= font_byte;
`ifdef CHRONI_TEXT_ATTR_EN
                            bus.lb_bitmap_on  <= {4'h0, attr_buf[col][3:0]};
                            bus.lb_bitmap_off <= {4'h0, attr_buf[col][7:4]};
`else
                            bus.lb_bitmap_on  <= 8'h01;
                            bus.lb_bitmap_off <= 8'h00;
`endif
                            if (last_col) begin
                                line_done <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                col   <= col + 1'b1;
                                state <= FONT_REQ;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
